// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default word size.
package uart_pkg;

  localparam int DATA_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Received-word port bundle: the receiver drives it (master), the consumer reads it (slave).
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;

  modport master (output rx_data, output rx_valid, output frame_err, output parity_err);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  parity_err);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a history flop for falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic RSTn,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Idle-high line: reset to 1 so release never looks like a start edge.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rx_s = sync_q;
  assign fall = hist_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver FSM and datapath; sampling is paced by an external mid-bit strobe.
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data bits.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synced line, baud generator off
// START  | waiting for mid start bit strobe; high there means glitch
// DATA   | shifting in DATA_BITS bits, LSB first
// PARITY | sampling the parity bit (parity build only)
// STOP   | checking the stop bit, publishing the word or flagging a frame error
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          rx,
  input  logic          clk_uart,
  output logic          bps_en,
  output logic          busy,
  uart_rx_if.master     rx_if
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
  end

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .RSTn (RSTn),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q, parity_bit_d;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (clk_uart) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (clk_uart) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (clk_uart) begin
          parity_bit_d = rx_s;
          state_d      = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (clk_uart) begin
          state_d = IDLE;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = (^shift_q) ^ parity_bit_q ^ PARITY_ODD[0];
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) parity_bit_q <= 1'b0;
    else       parity_bit_q <= parity_bit_d;
  end
`endif

  // The baud generator runs for the whole frame and restarts on each new start edge.
  assign busy   = (state_q != IDLE);
  assign bps_en = (state_q != IDLE);

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity (used only with UART_RX_PARITY_EN).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port clk_uart  input  1  one-cycle mid-bit sample strobe from the baud generator.
REQ-007 SHALL have port bps_en  output  1  baud generator enable; the generator counter restarts from 0 on its rising edge.
REQ-008 SHALL have port rx_data  output  DATA_BITS  last good received word, LSB first on the line.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port parity_err  output  1  qualifier valid in the rx_valid cycle.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL pass rx through a two-flop synchronizer plus one history flop; a falling edge is synced high->low.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, all registered.
REQ-015 In IDLE, a falling edge SHALL cause START and bps_en=1 the next cycle; edges are ignored in all other states.
REQ-016 In START, on clk_uart with synced rx=0: go to DATA and clear bit_cnt; with rx=1 (glitch): go to IDLE, bps_en=0, no pulses.
REQ-017 In DATA, each clk_uart SHALL shift the synced rx into the shift-register MSB and increment bit_cnt; after DATA_BITS samples, go to PARITY (macro) or STOP.
REQ-018 In STOP, on clk_uart with rx=1: rx_data<=shift register and rx_valid=1 for exactly one cycle, the cycle after the strobe.
REQ-019 In STOP, on clk_uart with rx=0: frame_err=1 for one cycle, rx_valid=0, and rx_data unchanged.
REQ-020 Leaving STOP SHALL go to IDLE with bps_en=0 the next cycle; a new falling edge is accepted from the following cycle.
REQ-021 A line held low (break) SHALL produce one frame_err and then remain in IDLE until rx returns high and falls again.
REQ-022 clk_uart SHALL be ignored in IDLE.
REQ-023 bit_cnt SHALL be $clog2(DATA_BITS+1) bits wide and never wrap.

Reset
REQ-024 RSTn low SHALL immediately force state=IDLE and bps_en, rx_valid, frame_err, parity_err, busy, rx_data, shift register and bit_cnt to 0; synchronizer flops reset to 1.
REQ-025 Reset mid-frame SHALL discard the frame; reception resumes on the next falling edge after release.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, after DATA the PARITY state SHALL sample one bit on clk_uart, then go to STOP.
REQ-027 With UART_RX_PARITY_EN, parity_err SHALL equal (XOR of data ^ parity bit ^ PARITY_ODD) != 0, presented with rx_valid.
REQ-028 Without UART_RX_PARITY_EN, the PARITY state SHALL be unreachable and parity_err SHALL be tied to 0.

Structure
REQ-029 State encoding and the DATA_BITS default SHALL be defined in shared package uart_pkg, for reuse by the transmitter.
REQ-030 The synchronizer and edge detector SHALL be sub-module uart_rx_sync (outputs rx_s and fall); the FSM and datapath stay in uart_rx.

Verification
REQ-031 The bench SHALL pair the block with the baud generator, BPS_PARA=434, 50 MHz clk, 8N1, and cover the following scenarios.
REQ-032 Frame 0x55, stop=1 -> rx_data=0x55, one rx_valid pulse, frame_err=0, bps_en low after STOP.
REQ-033 rx low for 100 clk, then high -> START samples 1, return to IDLE, no rx_valid or frame_err.
REQ-034 Frame 0xA3 with stop=0 -> one frame_err pulse, no rx_valid, rx_data keeps its previous value.
REQ-035 Back-to-back frames 0x01 then 0xFF, no idle gap -> two rx_valid pulses with 0x01 then 0xFF.
REQ-036 RSTn low mid-DATA -> all outputs 0 immediately; the next frame 0xC3 is received correctly.
REQ-037 With UART_RX_PARITY_EN and even parity, frame 0x0F with parity bit 1 -> rx_valid with parity_err=1; with parity bit 0 -> parity_err=0.
